// File: rtl/fu_load_multi.sv
// fu_load_multi: non-blocking load unit with DEPTH in-flight entries (SQ forward, D-cache, extract)
module fu_load_multi #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int SQ_IDX_W = 3,
    parameter int PR_W     = 6,
    parameter int ROB_W    = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_base,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [2:0]          in_funct3,
    input  logic [PR_W-1:0]     in_dest_pr,
    input  logic [ROB_W-1:0]    in_rob_entry,
    input  logic [SQ_IDX_W-1:0] in_sq_tail,
    output logic                sq_lookup_valid,
    output logic [XLEN-1:0]     sq_lookup_addr,
    output logic [SQ_IDX_W-1:0] sq_lookup_tail,
    input  logic                sq_stall,
    input  logic [3:0]          sq_usebytes,
    input  logic [XLEN-1:0]     sq_data,
    output logic                cache_rd_en,
    output logic [XLEN-1:0]     cache_addr,
    input  logic                cache_hit,
    input  logic [XLEN-1:0]     cache_data,
    output logic                cmp_valid,
    input  logic                cmp_stall,
    output logic [PR_W-1:0]     cmp_dest_pr,
    output logic [ROB_W-1:0]    cmp_rob_entry,
    output logic [XLEN-1:0]     cmp_value
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {FREE, SQ, CACHE, DONE} state_t;

    state_t                state      [DEPTH];
    state_t                state_next [DEPTH];
    logic [XLEN-1:0]       addr       [DEPTH];
    logic [2:0]            funct3     [DEPTH];
    logic [PR_W-1:0]       dest_pr    [DEPTH];
    logic [ROB_W-1:0]      rob_entry  [DEPTH];
    logic [SQ_IDX_W-1:0]   sq_tail    [DEPTH];
    logic [3:0]            fwd_bytes  [DEPTH];
    logic [XLEN-1:0]       data       [DEPTH];

    logic                  lock;
    logic [IW-1:0]         lock_idx;
    logic                  kill, alloc;
    logic                  free_ok, sq_ok, ca_ok, dn_ok;
    logic [IW-1:0]         free_idx, sq_idx, ca_idx, dn_idx;
    logic                  sq_go, ca_go, dn_go, sq_full;
    logic [3:0]            sq_need;
    logic [XLEN-1:0]       merged;

    function automatic logic [3:0] use_bytes(input logic [1:0] off, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: use_bytes = 4'b0001 << off;
            3'b001, 3'b101: use_bytes = off[1] ? 4'b1100 : 4'b0011;
            3'b010:         use_bytes = 4'b1111;
            default:        use_bytes = 4'b0000;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extract(input logic [1:0] off, input logic [2:0] f3,
                                                input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[16 +: 16] : word[0 +: 16];
        case (f3)
            3'b000:  extract = {{(XLEN-8){b[7]}}, b};
            3'b100:  extract = {{(XLEN-8){1'b0}}, b};
            3'b001:  extract = {{(XLEN-16){h[15]}}, h};
            3'b101:  extract = {{(XLEN-16){1'b0}}, h};
            3'b010:  extract = word;
            default: extract = '0;
        endcase
    endfunction

    // Fixed-priority pickers: lowest index per state; a stalled completion stays locked on its entry
    always_comb begin
        free_ok  = 1'b0;
        sq_ok    = 1'b0;
        ca_ok    = 1'b0;
        dn_ok    = 1'b0;
        free_idx = '0;
        sq_idx   = '0;
        ca_idx   = '0;
        dn_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state[i] == FREE)  begin free_ok = 1'b1; free_idx = IW'(i); end
            if (state[i] == SQ)    begin sq_ok   = 1'b1; sq_idx   = IW'(i); end
            if (state[i] == CACHE) begin ca_ok   = 1'b1; ca_idx   = IW'(i); end
            if (state[i] == DONE)  begin dn_ok   = 1'b1; dn_idx   = IW'(i); end
        end
        if (lock) begin
            dn_ok  = 1'b1;
            dn_idx = lock_idx;
        end
    end

    assign kill     = squash || reset;
    assign in_ready = free_ok && !squash;
    assign alloc    = in_valid && in_ready && !reset;
    assign sq_go    = sq_ok && !kill;
    assign ca_go    = ca_ok && !kill;
    assign dn_go    = dn_ok && !kill;
    assign sq_need  = use_bytes(addr[sq_idx][1:0], funct3[sq_idx]);
    assign sq_full  = (sq_need & sq_usebytes) == sq_need;

    // Cache-hit merge: forwarded store bytes override the cache line bytes
    always_comb begin
        merged = cache_data;
        for (int b = 0; b < 4; b++)
            merged[8*b +: 8] = fwd_bytes[ca_idx][b] ? data[ca_idx][8*b +: 8] : cache_data[8*b +: 8];
    end

    // Per-entry next state; at most one advance per entry since each entry sits in one stage
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            state_next[i] = kill ? FREE : state[i];
        if (alloc)
            state_next[free_idx] = SQ;
        if (sq_go && !sq_stall)
            state_next[sq_idx] = sq_full ? DONE : CACHE;
        if (ca_go && cache_hit)
            state_next[ca_idx] = DONE;
        if (dn_go && !cmp_stall)
            state_next[dn_idx] = FREE;
    end

    // Entry state register
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                state[i] <= FREE;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                state[i] <= state_next[i];
        end
    end

    // Entry payload: captured at allocate, updated by SQ response and cache hit
    always_ff @(posedge clock) begin
        if (alloc) begin
            addr[free_idx]      <= in_base + in_imm;
            funct3[free_idx]    <= in_funct3;
            dest_pr[free_idx]   <= in_dest_pr;
            rob_entry[free_idx] <= in_rob_entry;
            sq_tail[free_idx]   <= in_sq_tail;
            fwd_bytes[free_idx] <= '0;
        end
        if (sq_go && !sq_stall) begin
            fwd_bytes[sq_idx] <= sq_usebytes;
            data[sq_idx]      <= sq_data;
        end
        if (ca_go && cache_hit)
            data[ca_idx] <= merged;
    end

    // Completion lock keeps cmp_* pinned to one entry while the complete stage stalls
    always_ff @(posedge clock) begin
        if (kill) begin
            lock <= 1'b0;
        end else begin
            lock     <= dn_go && cmp_stall;
            lock_idx <= dn_idx;
        end
    end

    assign sq_lookup_valid = sq_go;
    assign sq_lookup_addr  = sq_go ? {addr[sq_idx][XLEN-1:2], 2'b00} : '0;
    assign sq_lookup_tail  = sq_go ? sq_tail[sq_idx] : '0;
    assign cache_rd_en     = ca_go;
    assign cache_addr      = ca_go ? {addr[ca_idx][XLEN-1:2], 2'b00} : '0;
    assign cmp_valid       = dn_go;
    assign cmp_dest_pr     = dn_go ? dest_pr[dn_idx] : '0;
    assign cmp_rob_entry   = dn_go ? rob_entry[dn_idx] : '0;
    assign cmp_value       = dn_go ? extract(addr[dn_idx][1:0], funct3[dn_idx], data[dn_idx]) : '0;
endmodule

// File: tb/tb_fu_load_multi.sv
// tb_fu_load_multi: directed and random checks of fu_load_multi against a slot-level reference model
module tb_fu_load_multi;
    logic        clock = 1'b0;
    logic        reset, squash, in_valid, in_ready;
    logic [31:0] in_base, in_imm;
    logic [2:0]  in_funct3;
    logic [5:0]  in_dest_pr;
    logic [4:0]  in_rob_entry;
    logic [2:0]  in_sq_tail;
    logic        sq_lookup_valid;
    logic [31:0] sq_lookup_addr;
    logic [2:0]  sq_lookup_tail;
    logic        sq_stall;
    logic [3:0]  sq_usebytes;
    logic [31:0] sq_data;
    logic        cache_rd_en;
    logic [31:0] cache_addr;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        cmp_valid, cmp_stall;
    logic [5:0]  cmp_dest_pr;
    logic [4:0]  cmp_rob_entry;
    logic [31:0] cmp_value;

    fu_load_multi dut (
        .clock(clock), .reset(reset), .squash(squash),
        .in_valid(in_valid), .in_ready(in_ready), .in_base(in_base), .in_imm(in_imm),
        .in_funct3(in_funct3), .in_dest_pr(in_dest_pr), .in_rob_entry(in_rob_entry),
        .in_sq_tail(in_sq_tail),
        .sq_lookup_valid(sq_lookup_valid), .sq_lookup_addr(sq_lookup_addr),
        .sq_lookup_tail(sq_lookup_tail), .sq_stall(sq_stall), .sq_usebytes(sq_usebytes),
        .sq_data(sq_data),
        .cache_rd_en(cache_rd_en), .cache_addr(cache_addr), .cache_hit(cache_hit),
        .cache_data(cache_data),
        .cmp_valid(cmp_valid), .cmp_stall(cmp_stall), .cmp_dest_pr(cmp_dest_pr),
        .cmp_rob_entry(cmp_rob_entry), .cmp_value(cmp_value)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Reference slots: stage 0 free, 1 waiting on SQ, 2 waiting on cache, 3 ready to complete
    int          m_st  [4];
    logic [31:0] m_a   [4];
    logic [31:0] m_w   [4];
    logic [2:0]  m_f   [4];
    logic [2:0]  m_tl  [4];
    logic [5:0]  m_pr  [4];
    logic [4:0]  m_rob [4];
    logic [3:0]  m_fw  [4];
    bit          m_lock = 1'b0;
    int          m_li   = 0;
    logic [5:0]  done_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ub_of(input logic [31:0] a, input logic [2:0] f);
        int off = int'(a % 4);
        if (f == 3'd0 || f == 3'd4) return 4'(1 << off);
        if (f == 3'd1 || f == 3'd5) return (off >= 2) ? 4'd12 : 4'd3;
        if (f == 3'd2) return 4'd15;
        return 4'd0;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] a, input logic [2:0] f, input logic [31:0] w);
        logic [31:0] b = (w >> (8 * (a % 4))) & 32'hFF;
        logic [31:0] h = (w >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            3'd2:    return w;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model();
        int s = -1, c = -1, d = -1, fr = -1;
        bit kill;
        logic [3:0]  ub;
        logic [31:0] mw;
        for (int i = 3; i >= 0; i--) begin
            if (m_st[i] == 0) fr = i;
            if (m_st[i] == 1) s = i;
            if (m_st[i] == 2) c = i;
            if (m_st[i] == 3) d = i;
        end
        if (m_lock) d = m_li;
        kill = squash || reset;
        if (!reset) check("in_ready", 32'(in_ready), 32'(fr >= 0 && !squash));
        check("sq_valid", 32'(sq_lookup_valid), 32'(s >= 0 && !kill));
        if (s >= 0 && !kill) begin
            check("sq_addr", sq_lookup_addr, m_a[s] & ~32'h3);
            check("sq_tail", 32'(sq_lookup_tail), 32'(m_tl[s]));
        end
        check("rd_en", 32'(cache_rd_en), 32'(c >= 0 && !kill));
        if (c >= 0 && !kill) check("cache_addr", cache_addr, m_a[c] & ~32'h3);
        check("cmp_valid", 32'(cmp_valid), 32'(d >= 0 && !kill));
        if (d >= 0 && !kill) begin
            check("cmp_pr", 32'(cmp_dest_pr), 32'(m_pr[d]));
            check("cmp_rob", 32'(cmp_rob_entry), 32'(m_rob[d]));
            check("cmp_value", cmp_value, ext(m_a[d], m_f[d], m_w[d]));
        end
        if (kill) begin
            for (int i = 0; i < 4; i++) m_st[i] = 0;
            m_lock = 1'b0;
            return;
        end
        if (in_valid && fr >= 0) begin
            m_st[fr]  = 1;
            m_a[fr]   = in_base + in_imm;
            m_f[fr]   = in_funct3;
            m_pr[fr]  = in_dest_pr;
            m_rob[fr] = in_rob_entry;
            m_tl[fr]  = in_sq_tail;
        end
        if (s >= 0 && !sq_stall) begin
            ub      = ub_of(m_a[s], m_f[s]);
            m_w[s]  = sq_data;
            m_fw[s] = sq_usebytes;
            m_st[s] = ((ub & sq_usebytes) == ub) ? 3 : 2;
        end
        if (c >= 0 && cache_hit) begin
            mw = 32'd0;
            for (int b = 0; b < 4; b++)
                mw |= (m_fw[c][b] ? m_w[c] : cache_data) & (32'hFF << (8 * b));
            m_w[c]  = mw;
            m_st[c] = 3;
        end
        m_lock = (d >= 0) && cmp_stall;
        m_li   = d;
        if (d >= 0 && !cmp_stall) m_st[d] = 0;
    endtask

    task automatic go();
        #1;
        if (cmp_valid && !cmp_stall && !squash && !reset) done_q.push_back(cmp_dest_pr);
        model();
        @(negedge clock);
    endtask

    task automatic idle();
        in_valid = 0; in_base = 0; in_imm = 0; in_funct3 = 0; in_dest_pr = 0;
        in_rob_entry = 0; in_sq_tail = 0; squash = 0; sq_stall = 0; sq_usebytes = 0;
        sq_data = 0; cache_hit = 0; cache_data = 0; cmp_stall = 0;
    endtask

    task automatic issue(input logic [31:0] b, input logic [31:0] i, input logic [2:0] f,
                         input logic [5:0] pr);
        in_valid = 1; in_base = b; in_imm = i; in_funct3 = f;
        in_dest_pr = pr; in_rob_entry = pr[4:0]; in_sq_tail = pr[2:0];
    endtask

    initial begin
        logic [31:0] v0;
        logic [5:0]  p0;
        idle();
        reset = 1;
        @(negedge clock);
        go();
        go();
        reset = 0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_sq_v", 32'(sq_lookup_valid), 32'd0);
        check("rst_rd_en", 32'(cache_rd_en), 32'd0);
        check("rst_cmp_v", 32'(cmp_valid), 32'd0);
        check("rst_sq_addr", sq_lookup_addr, 32'd0);
        check("rst_caddr", cache_addr, 32'd0);
        check("rst_cmp_val", cmp_value, 32'd0);
        go();

        // LW through the cache
        issue(32'h1000, 32'd4, 3'b010, 6'd1); go(); in_valid = 0;
        #1 check("t1_sq_v", 32'(sq_lookup_valid), 32'd1);
        check("t1_sq_addr", sq_lookup_addr, 32'h1004);
        go();
        cache_hit = 1; cache_data = 32'hDEADBEEF;
        #1 check("t1_rd_en", 32'(cache_rd_en), 32'd1);
        check("t1_caddr", cache_addr, 32'h1004);
        go(); cache_hit = 0;
        #1 check("t1_cmp_v", 32'(cmp_valid), 32'd1);
        check("t1_value", cmp_value, 32'hDEADBEEF);
        go();

        // LBU fully forwarded
        issue(32'h2000, 32'd3, 3'b100, 6'd2); go(); in_valid = 0;
        sq_usebytes = 4'b1000; sq_data = 32'hAB000000; go(); sq_usebytes = 0;
        #1 check("t2_rd_en", 32'(cache_rd_en), 32'd0);
        check("t2_cmp_v", 32'(cmp_valid), 32'd1);
        check("t2_value", cmp_value, 32'h000000AB);
        go();

        // LH with partial forward merged into cache data
        issue(32'h2000, 32'd2, 3'b001, 6'd3); go(); in_valid = 0;
        sq_usebytes = 4'b0100; sq_data = 32'h00800000; go(); sq_usebytes = 0;
        cache_hit = 1; cache_data = 32'h92345678; go(); cache_hit = 0;
        #1 check("t3_value", cmp_value, 32'hFFFF9280);
        go();

        // Fill all entries behind a stalled SQ, then drain in order
        done_q.delete();
        sq_stall = 1;
        for (int i = 0; i < 4; i++) begin
            issue(32'h3000 + 32'(4 * i), 32'd0, 3'b010, 6'(10 + i));
            go();
        end
        in_valid = 0;
        #1 check("t4_full", 32'(in_ready), 32'd0);
        go();
        sq_stall = 0; sq_usebytes = 4'hF; sq_data = 32'h0BADF00D;
        for (int k = 0; k < 12; k++) go();
        sq_usebytes = 0;
        check("t4_count", 32'(done_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < done_q.size(); i++)
            check("t4_order", 32'(done_q[i]), 32'(10 + i));

        // Cache miss on entry 0 does not block a forwarded entry 1
        done_q.delete();
        issue(32'h4000, 32'd0, 3'b010, 6'd20); go();
        issue(32'h4010, 32'd0, 3'b010, 6'd21); go(); in_valid = 0;
        sq_usebytes = 4'hF; sq_data = 32'h11223344; go(); sq_usebytes = 0;
        go(); go();
        cache_hit = 1; cache_data = 32'h55667788; go(); cache_hit = 0;
        for (int k = 0; k < 4; k++) go();
        check("t5_count", 32'(done_q.size()), 32'd2);
        if (done_q.size() == 2) begin
            check("t5_first", 32'(done_q[0]), 32'd21);
            check("t5_second", 32'(done_q[1]), 32'd20);
        end

        // Completion stall holds outputs, then squash with three entries live
        issue(32'h5000, 32'd0, 3'b010, 6'd30); go(); in_valid = 0;
        sq_usebytes = 4'hF; sq_data = 32'h12345678; go(); sq_usebytes = 0;
        cmp_stall = 1; sq_stall = 1;
        issue(32'h5004, 32'd0, 3'b010, 6'd31);
        #1 v0 = cmp_value; p0 = cmp_dest_pr;
        check("t6_value", v0, 32'h12345678);
        go();
        issue(32'h5008, 32'd0, 3'b010, 6'd32);
        #1 check("t6_hold_v", cmp_value, v0);
        check("t6_hold_pr", 32'(cmp_dest_pr), 32'(p0));
        go(); in_valid = 0;
        #1 check("t6_hold_c", 32'(cmp_valid), 32'd1);
        check("t6_hold_pr2", 32'(cmp_dest_pr), 32'd30);
        go();
        squash = 1;
        #1 check("t6_sq_cmp_v", 32'(cmp_valid), 32'd0);
        check("t6_sq_sq_v", 32'(sq_lookup_valid), 32'd0);
        go();
        squash = 0; cmp_stall = 0; sq_stall = 0;
        #1 check("t6_post_ready", 32'(in_ready), 32'd1);
        check("t6_post_cmp", 32'(cmp_valid), 32'd0);
        go();

        // Random traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            in_valid     = $urandom_range(0, 99) < 60;
            in_base      = $urandom;
            in_imm       = 32'($urandom_range(0, 4095)) - 32'd2048;
            in_funct3    = 3'($urandom_range(0, 7));
            in_dest_pr   = 6'($urandom);
            in_rob_entry = 5'($urandom);
            in_sq_tail   = 3'($urandom);
            squash       = $urandom_range(0, 99) < 3;
            reset        = $urandom_range(0, 499) == 0;
            sq_stall     = $urandom_range(0, 99) < 25;
            sq_usebytes  = 4'($urandom);
            sq_data      = $urandom;
            cache_hit    = $urandom_range(0, 99) < 50;
            cache_data   = $urandom;
            cmp_stall    = $urandom_range(0, 99) < 30;
            go();
        end
        idle();
        reset = 0;
        for (int k = 0; k < 10; k++) go();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
